comma_aligned_deserializer: RTL and testbench
=============================================

// Module: comma_aligned_deserializer
// PURPOSE
//  Parametrised RX deserializer: shifts in the recovered serial stream, finds symbol boundaries
//  by comma (K28.5) detection, and presents aligned SYMBOL_W-bit words with a one-cycle valid
//  strobe to the 8b/10b decoder. Supports optional polarity inversion, a free-running
//  (unaligned) mode, and optional realignment after repeated misaligned commas.
// PARAMETERS
//  SYMBOL_W        10             symbol width in bits (>=4)
//  COMMA_P         10'b0011111010 comma pattern, RD-, in Data_To_Decoder orientation
//  COMMA_N         10'b1100000101 comma pattern, RD+
//  MISALIGN_LIMIT  3              consecutive misaligned commas that force a realign (>=1)
// PORTS
//  Recovered_Bit_Clk  in   1         recovered bit clock; all logic on rising edge
//  Rst                in   1         synchronous reset, active-high
//  Ser_In             in   1         serial data bit, one per clock
//  RxPolarity         in   1         1: invert Ser_In before capture
//  Align_En           in   1         1: comma alignment active; 0: free-running framing
//  Data_To_Decoder    out  SYMBOL_W  aligned symbol; bit 0 = earliest received bit
//  Data_Valid         out  1         one-cycle pulse when Data_To_Decoder updates
//  Comma_Det          out  1         one-cycle pulse, qualifies Data_Valid: symbol is a comma
//  Aligned            out  1         1 while in LOCKED state
// BEHAVIOUR
//  - Reset: Shift_Reg=0, Ph=0, misalign count=0, state=SEARCH; Data_To_Decoder=0,
//    Data_Valid=0, Comma_Det=0, Aligned=0. Rst dominates all other inputs.
//  - Capture: b = Ser_In ^ RxPolarity; Shift_Reg <= {b, Shift_Reg[SYMBOL_W-1:1]} every edge,
//    in all states. Window match M = (Shift_Reg==COMMA_P)|(Shift_Reg==COMMA_N), registered value.
//  - Phase counter Ph: 0..SYMBOL_W-1, wraps to 0; "boundary" = (Ph==SYMBOL_W-1).
//  - Output latency: last bit of a symbol captured at edge n; Data_To_Decoder/Data_Valid at edge n+1.
//  - Align_En=0: state forced to SEARCH, Aligned=0; Ph free-runs; at each boundary
//    Data_To_Decoder<=Shift_Reg, Data_Valid=1, Comma_Det=M. No comma search.
//  - SEARCH (Align_En=1): Data_Valid=0 until M. On M: Data_To_Decoder<=Shift_Reg,
//    Data_Valid=1, Comma_Det=1, Ph<=0, state->LOCKED, misalign count=0.
//  - LOCKED: Aligned=1. At boundary: Data_To_Decoder<=Shift_Reg, Data_Valid=1, Comma_Det=M;
//    if M, misalign count<=0. Off boundary with M: misaligned comma (see CONFIGURATION).
//    Off boundary without M: no output change. Next symbol emitted exactly SYMBOL_W edges later.
//  - Align_En 1->0 while LOCKED: exit to SEARCH next edge, keep Ph running; 0->1: search anew.
//  - Outputs hold value between strobes; Data_Valid/Comma_Det are low on all non-emit cycles.
// CONFIGURATION
//  Macro SER_REALIGN_EN:
//  - defined: LOCKED off-boundary M increments misalign count (saturating); boundary comma or
//    reset clears it. When the increment reaches MISALIGN_LIMIT, in that same edge realign to
//    the current window: Data_To_Decoder<=Shift_Reg, Data_Valid=1, Comma_Det=1, Ph<=0, count<=0,
//    stay LOCKED. Non-comma misalignments between commas do not clear the count.
//  - undefined: off-boundary commas ignored; alignment held until Rst or Align_En=0; no count
//    register is built.
// TESTING
//  1 Rst=1 for 3 clocks with random Ser_In -> all outputs 0, Aligned=0, no Data_Valid.
//  2 Align_En=1, 7 random bits then 0011111010 (bit0 first) then data 0x2AA -> Data_Valid+Comma_Det
//    one edge after comma's last bit, Aligned=1; 0x2AA emitted exactly 10 edges later, Comma_Det=0.
//  3 RxPolarity=1, send inverted comma 1100000101 -> detected as COMMA_N; next symbol un-inverted.
//  4 Locked, then stream shifted by 3 bits with commas every 5 symbols -> with SER_REALIGN_EN:
//    realign on 3rd misaligned comma, emitted as Comma_Det; without: phase unchanged, no realign.
//  5 Align_En=0, 30 bits 0x155-pattern -> Data_Valid every 10 clocks from reset, Aligned=0.
//  6 Rst asserted mid-symbol while LOCKED -> next edge all outputs 0, SEARCH; relock on next comma.

Source files
------------

// File: rtl/comma_aligned_deserializer.sv
// rtl/comma_aligned_deserializer.sv - comma-aligned RX deserializer; `define SER_REALIGN_EN enables realign on repeated misaligned commas
module comma_aligned_deserializer #(
    parameter int                  SYMBOL_W       = 10,
    parameter logic [SYMBOL_W-1:0] COMMA_P        = 10'b0011111010,
    parameter logic [SYMBOL_W-1:0] COMMA_N        = 10'b1100000101,
    parameter int                  MISALIGN_LIMIT = 3
) (
    input  logic                Recovered_Bit_Clk,
    input  logic                Rst,
    input  logic                Ser_In,
    input  logic                RxPolarity,
    input  logic                Align_En,
    output logic [SYMBOL_W-1:0] Data_To_Decoder,
    output logic                Data_Valid,
    output logic                Comma_Det,
    output logic                Aligned
);

    localparam int PH_W = $clog2(SYMBOL_W);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SYMBOL_W - 1);

    if (SYMBOL_W < 4 || MISALIGN_LIMIT < 1) begin : g_param_check
        $error("comma_aligned_deserializer: SYMBOL_W must be >= 4 and MISALIGN_LIMIT >= 1");
    end

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [SYMBOL_W-1:0] shift_reg;
    logic [PH_W-1:0]     ph, ph_next;
    logic                bit_in;
    logic                match;
    logic                boundary;
    logic                emit;
    logic                emit_comma;

`ifdef SER_REALIGN_EN
    localparam int CNT_W = $clog2(MISALIGN_LIMIT + 1);
    logic [CNT_W-1:0] mis_cnt, mis_cnt_next, mis_cnt_inc;
    assign mis_cnt_inc = mis_cnt + CNT_W'(1);
`endif

    assign bit_in   = Ser_In ^ RxPolarity;
    // Match is taken on the registered window, so it describes the symbol completed last edge.
    assign match    = (shift_reg == COMMA_P) || (shift_reg == COMMA_N);
    assign boundary = (ph == PH_LAST);
    assign Aligned  = (state == LOCKED);

    always_comb begin
        state_next = state;
        ph_next    = boundary ? '0 : ph + PH_W'(1);
        emit       = 1'b0;
        emit_comma = 1'b0;
`ifdef SER_REALIGN_EN
        mis_cnt_next = mis_cnt;
`endif
        if (!Align_En) begin
            state_next = SEARCH;
            if (boundary) begin
                emit       = 1'b1;
                emit_comma = match;
            end
        end else begin
            case (state)
                SEARCH: begin
                    if (match) begin
                        emit       = 1'b1;
                        emit_comma = 1'b1;
                        ph_next    = '0;
                        state_next = LOCKED;
`ifdef SER_REALIGN_EN
                        mis_cnt_next = '0;
`endif
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        emit       = 1'b1;
                        emit_comma = match;
`ifdef SER_REALIGN_EN
                        if (match) mis_cnt_next = '0;
`endif
                    end else if (match) begin
`ifdef SER_REALIGN_EN
                        // Enough off-phase commas: snap framing to the current window.
                        if (mis_cnt_inc >= CNT_W'(MISALIGN_LIMIT)) begin
                            emit         = 1'b1;
                            emit_comma   = 1'b1;
                            ph_next      = '0;
                            mis_cnt_next = '0;
                        end else begin
                            mis_cnt_next = mis_cnt_inc;
                        end
`endif
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
    end

    always_ff @(posedge Recovered_Bit_Clk) begin
        if (Rst) begin
            shift_reg       <= '0;
            ph              <= '0;
            state           <= SEARCH;
            Data_To_Decoder <= '0;
            Data_Valid      <= 1'b0;
            Comma_Det       <= 1'b0;
`ifdef SER_REALIGN_EN
            mis_cnt         <= '0;
`endif
        end else begin
            shift_reg  <= {bit_in, shift_reg[SYMBOL_W-1:1]};
            ph         <= ph_next;
            state      <= state_next;
            Data_Valid <= emit;
            Comma_Det  <= emit_comma;
            if (emit) Data_To_Decoder <= shift_reg;
`ifdef SER_REALIGN_EN
            mis_cnt    <= mis_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_comma_aligned_deserializer.sv
// tb/tb_comma_aligned_deserializer.sv - directed self-checking bench for comma_aligned_deserializer
module tb_comma_aligned_deserializer;

    localparam logic [9:0] CP  = 10'b0011111010;
    localparam logic [9:0] CN  = 10'b1100000101;
    localparam logic [9:0] D   = 10'h2AA;
    localparam logic [9:0] D55 = 10'h155;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_in;
    logic       rx_polarity;
    logic       align_en;
    logic [9:0] data_out;
    logic       data_valid;
    logic       comma_det;
    logic       aligned;

    int tests_run = 0;
    int tests_failed = 0;

    int         vcount;
    int         vidx;
    logic [9:0] vdata;
    logic       vcomma;

    comma_aligned_deserializer dut (
        .Recovered_Bit_Clk(clk),
        .Rst(rst),
        .Ser_In(ser_in),
        .RxPolarity(rx_polarity),
        .Align_En(align_en),
        .Data_To_Decoder(data_out),
        .Data_Valid(data_valid),
        .Comma_Det(comma_det),
        .Aligned(aligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ser_in = b;
        @(posedge clk);
        #1;
    endtask

    // Sends v bit 0 first and records the last Data_Valid pulse seen during the ten edges.
    task automatic send_sym(input logic [9:0] v);
        vcount = 0;
        vidx   = -1;
        vdata  = '0;
        vcomma = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_bit(v[i]);
            if (data_valid) begin
                vcount++;
                vidx   = i;
                vdata  = data_out;
                vcomma = comma_det;
            end
        end
    endtask

    task automatic do_reset(input logic en);
        align_en = en;
        rst = 1'b1;
        repeat (3) send_bit(1'($urandom_range(0, 1)));
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ser_in = 1'b0;
        rx_polarity = 1'b0;
        align_en = 1'b0;

        // Reset: outputs stay zero whatever arrives on the line
        align_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(1'($urandom_range(0, 1)));
            check("rst_data", 32'(data_out), 32'h0);
            check("rst_valid", 32'(data_valid), 32'h0);
            check("rst_comma", 32'(comma_det), 32'h0);
            check("rst_aligned", 32'(aligned), 32'h0);
        end
        rst = 1'b0;

        // Comma acquisition and first data symbol
        vcount = 0;
        for (int i = 0; i < 7; i++) begin
            send_bit(1'b0);
            if (data_valid) vcount++;
        end
        check("pre_comma_valids", 32'(vcount), 32'h0);
        send_sym(CP);
        check("comma_sym_valids", 32'(vcount), 32'h0);
        send_sym(D);
        check("lock_count", 32'(vcount), 32'h1);
        check("lock_idx", 32'(vidx), 32'h0);
        check("lock_data", 32'(vdata), 32'(CP));
        check("lock_comma", 32'(vcomma), 32'h1);
        check("lock_aligned", 32'(aligned), 32'h1);
        send_sym(D);
        check("data_count", 32'(vcount), 32'h1);
        check("data_idx", 32'(vidx), 32'h0);
        check("data_value", 32'(vdata), 32'(D));
        check("data_comma", 32'(vcomma), 32'h0);

        // Polarity inversion: wire carries ~COMMA_N, decoder sees COMMA_N
        do_reset(1'b1);
        rx_polarity = 1'b1;
        send_sym(~CN);
        send_sym(~D);
        check("pol_idx", 32'(vidx), 32'h0);
        check("pol_data", 32'(vdata), 32'(CN));
        check("pol_comma", 32'(vcomma), 32'h1);
        send_sym(~D);
        check("pol_next_data", 32'(vdata), 32'(D));
        check("pol_next_comma", 32'(vcomma), 32'h0);
        rx_polarity = 1'b0;

        // Stream slips by three bits, then commas every five symbols
        do_reset(1'b1);
        send_sym(CP);
        send_sym(D);
        send_sym(D);
        send_bit(1'b0);
        check("slip_last_valid", 32'(data_valid), 32'h1);
        check("slip_last_data", 32'(data_out), 32'(D));
        send_bit(1'b1);
        send_bit(1'b0);
        send_sym(D);
        check("slip_idx", 32'(vidx), 32'h7);
        check("slip_data", 32'(vdata), 32'h152);
        for (int g = 0; g < 3; g++) begin
            send_sym(CP);
            send_sym(D);
            check("mis_count", 32'(vcount), 32'h1);
`ifdef SER_REALIGN_EN
            if (g == 2) begin
                check("realign_idx", 32'(vidx), 32'h0);
                check("realign_data", 32'(vdata), 32'(CP));
                check("realign_comma", 32'(vcomma), 32'h1);
            end else begin
                check("mis_idx", 32'(vidx), 32'h7);
                check("mis_comma", 32'(vcomma), 32'h0);
            end
`else
            check("mis_idx", 32'(vidx), 32'h7);
            check("mis_comma", 32'(vcomma), 32'h0);
`endif
            if (g < 2) repeat (3) send_sym(D);
        end
        send_sym(D);
`ifdef SER_REALIGN_EN
        check("post_realign_idx", 32'(vidx), 32'h0);
        check("post_realign_data", 32'(vdata), 32'(D));
`else
        check("held_phase_idx", 32'(vidx), 32'h7);
`endif
        check("slip_aligned", 32'(aligned), 32'h1);

        // Free-running framing from reset
        do_reset(1'b0);
        for (int s = 0; s < 3; s++) begin
            send_sym(D55);
            check("free_count", 32'(vcount), 32'h1);
            check("free_idx", 32'(vidx), 32'h9);
            check("free_data", 32'(vdata), 32'h2AA);
            check("free_comma", 32'(vcomma), 32'h0);
            check("free_aligned", 32'(aligned), 32'h0);
        end

        // Reset in the middle of a locked symbol, then relock
        do_reset(1'b1);
        send_sym(CP);
        send_sym(D);
        send_sym(D);
        check("pre_rst_aligned", 32'(aligned), 32'h1);
        for (int i = 0; i < 4; i++) send_bit(D[i]);
        rst = 1'b1;
        send_bit(1'b1);
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_valid", 32'(data_valid), 32'h0);
        check("mid_rst_comma", 32'(comma_det), 32'h0);
        check("mid_rst_aligned", 32'(aligned), 32'h0);
        rst = 1'b0;
        send_sym(CP);
        check("relock_quiet", 32'(vcount), 32'h0);
        send_sym(D);
        check("relock_idx", 32'(vidx), 32'h0);
        check("relock_data", 32'(vdata), 32'(CP));
        check("relock_comma", 32'(vcomma), 32'h1);
        check("relock_aligned", 32'(aligned), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
